// File: rtl/ma_xif_pkg.sv
// Shared types for the CV-X-IF matrix responder: custom-0 opcode, op/entry/dispatch
// enums and the instruction buffer entry layout.
package ma_xif_pkg;

    localparam logic [6:0]  MA_OPCODE = 7'b0001011;
    localparam int unsigned MA_ID_W   = 3;
    localparam int unsigned MA_XLEN   = 32;

    typedef enum logic [1:0] {LD = 2'd0, ST = 2'd1, MUL = 2'd2, CFG = 2'd3} ma_op_e;

    typedef enum logic [1:0] {PEND = 2'd0, COMMIT = 2'd1, KILL = 2'd2} entry_state_e;

    typedef enum logic [1:0] {IDLE = 2'd0, DISPATCH = 2'd1, WAIT = 2'd2, RESULT = 2'd3} disp_state_e;

    typedef struct packed {
        logic               valid;
        entry_state_e       state;
        logic [MA_ID_W-1:0] id;
        ma_op_e             op;
        logic [4:0]         rd;
        logic               wb;
        logic [MA_XLEN-1:0] rs1;
        logic [MA_XLEN-1:0] rs2;
    } ma_xif_entry_t;

endpackage

// File: rtl/ma_xif_decoder.sv
// Combinational decode of custom-0 matrix instructions: match, op, writeback and
// which source operands the op needs.
module ma_xif_decoder
    import ma_xif_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        match_o,
    output ma_op_e      op_o,
    output logic        wb_o,
    output logic [1:0]  need_rs_o,
    output logic [4:0]  rd_o
);

    // Register-specifier and funct7 fields are not interpreted by this engine.
    logic unused_bits;
    assign unused_bits = ^instr_i[31:15];

    assign match_o   = (instr_i[6:0] == MA_OPCODE) && !instr_i[14];
    assign op_o      = ma_op_e'(instr_i[13:12]);
    assign wb_o      = (op_o == CFG);
    assign need_rs_o = (op_o == CFG) ? 2'b01 : 2'b11;
    assign rd_o      = instr_i[11:7];

endmodule

// File: rtl/ma_xif_responder.sv
// CV-X-IF coprocessor responder for the matrix engine: decode/accept, buffer until
// commit or kill, in-order single-outstanding dispatch, and CFG writeback.
// Optional performance counters are built when MA_XIF_PERF_CNT_EN is defined.
module ma_xif_responder
    import ma_xif_pkg::*;
#(
    parameter int unsigned Depth   = 4,
    parameter int unsigned IdWidth = MA_ID_W,
    parameter int unsigned XLEN    = MA_XLEN
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [31:0]        issue_instr_i,
    input  logic [IdWidth-1:0] issue_id_i,
    input  logic [XLEN-1:0]    issue_rs1_i,
    input  logic [XLEN-1:0]    issue_rs2_i,
    input  logic [1:0]         issue_rs_valid_i,
    output logic               issue_accept_o,
    output logic               issue_writeback_o,
    output logic [1:0]         issue_register_read_o,
    input  logic               commit_valid_i,
    input  logic [IdWidth-1:0] commit_id_i,
    input  logic               commit_kill_i,
    output logic               result_valid_o,
    input  logic               result_ready_i,
    output logic [IdWidth-1:0] result_id_o,
    output logic [XLEN-1:0]    result_data_o,
    output logic [4:0]         result_rd_o,
    output logic               result_we_o,
    output logic               cmd_valid_o,
    input  logic               cmd_ready_i,
    output logic [1:0]         cmd_op_o,
    output logic [XLEN-1:0]    cmd_rs1_o,
    output logic [XLEN-1:0]    cmd_rs2_o,
    input  logic               done_i,
    input  logic [XLEN-1:0]    done_data_i,
    output logic [15:0]        perf_accepted_o,
    output logic [15:0]        perf_killed_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic        dec_match;
    ma_op_e      dec_op;
    logic        dec_wb;
    logic [1:0]  dec_need;
    logic [4:0]  dec_rd;

    ma_xif_decoder u_dec (
        .instr_i   (issue_instr_i),
        .match_o   (dec_match),
        .op_o      (dec_op),
        .wb_o      (dec_wb),
        .need_rs_o (dec_need),
        .rd_o      (dec_rd)
    );

    ma_xif_entry_t     ent_q [Depth];
    ma_xif_entry_t     head_ent;
    logic [PtrW-1:0]   head_q, tail_q;
    logic [CntW-1:0]   count_q;
    disp_state_e       state_q, state_d;
    logic              full, alloc, pop, load_cmd, latch_res;
    logic              commit_hit;
    logic [PtrW-1:0]   commit_idx;

    ma_op_e            cmd_op_q;
    logic [XLEN-1:0]   cmd_rs1_q, cmd_rs2_q, res_data_q;
    logic [IdWidth-1:0] cmd_id_q;
    logic [4:0]        cmd_rd_q;
    logic              cmd_wb_q;

    // Issue handshake is held off during reset so every output reads 0 then.
    assign full                  = (count_q == CntW'(Depth));
    assign issue_ready_o         = ~full & ~rst_i;
    assign alloc                 = issue_valid_i & dec_match & issue_ready_o
                                 & ((issue_rs_valid_i & dec_need) == dec_need);
    assign issue_accept_o        = alloc;
    assign issue_writeback_o     = alloc & dec_wb;
    assign issue_register_read_o = alloc ? dec_need : 2'b00;
    assign head_ent              = ent_q[head_q];

    // Only live PEND entries are commit targets; an entry allocated this cycle is not yet visible.
    always_comb begin
        commit_hit = 1'b0;
        commit_idx = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (!commit_hit && commit_valid_i && ent_q[i].valid &&
                ent_q[i].state == PEND && ent_q[i].id == commit_id_i) begin
                commit_hit = 1'b1;
                commit_idx = PtrW'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (commit_hit) begin
                ent_q[commit_idx].state <= commit_kill_i ? KILL : COMMIT;
            end
            if (pop) begin
                ent_q[head_q].valid <= 1'b0;
                head_q              <= head_q + PtrW'(1);
            end
            if (alloc) begin
                ent_q[tail_q] <= '{valid: 1'b1, state: PEND, id: issue_id_i, op: dec_op,
                                   rd: dec_rd, wb: dec_wb, rs1: issue_rs1_i, rs2: issue_rs2_i};
                tail_q        <= tail_q + PtrW'(1);
            end
            case ({alloc, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pop            = 1'b0;
        load_cmd       = 1'b0;
        latch_res      = 1'b0;
        cmd_valid_o    = 1'b0;
        result_valid_o = 1'b0;
        result_we_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (head_ent.valid && head_ent.state == KILL) begin
                    pop = 1'b1;
                end else if (head_ent.valid && head_ent.state == COMMIT) begin
                    load_cmd = 1'b1;
                    state_d  = DISPATCH;
                end
            end
            DISPATCH: begin
                cmd_valid_o = 1'b1;
                if (cmd_ready_i) begin
                    pop     = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (done_i) begin
                    latch_res = cmd_wb_q;
                    state_d   = cmd_wb_q ? RESULT : IDLE;
                end
            end
            RESULT: begin
                result_valid_o = 1'b1;
                result_we_o    = 1'b1;
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command and result registers only load in IDLE/WAIT, so they stay stable while presented.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_op_q   <= LD;
            cmd_rs1_q  <= '0;
            cmd_rs2_q  <= '0;
            cmd_id_q   <= '0;
            cmd_rd_q   <= '0;
            cmd_wb_q   <= 1'b0;
            res_data_q <= '0;
        end else begin
            if (load_cmd) begin
                cmd_op_q  <= head_ent.op;
                cmd_rs1_q <= head_ent.rs1;
                cmd_rs2_q <= head_ent.rs2;
                cmd_id_q  <= head_ent.id;
                cmd_rd_q  <= head_ent.rd;
                cmd_wb_q  <= head_ent.wb;
            end
            if (latch_res) begin
                res_data_q <= done_data_i;
            end
        end
    end

    assign cmd_op_o      = cmd_op_q;
    assign cmd_rs1_o     = cmd_rs1_q;
    assign cmd_rs2_o     = cmd_rs2_q;
    assign result_id_o   = cmd_id_q;
    assign result_rd_o   = cmd_rd_q;
    assign result_data_o = res_data_q;

`ifdef MA_XIF_PERF_CNT_EN
    logic [15:0] perf_acc_q, perf_kill_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_acc_q  <= '0;
            perf_kill_q <= '0;
        end else begin
            if (alloc && perf_acc_q != 16'hFFFF) begin
                perf_acc_q <= perf_acc_q + 16'd1;
            end
            if (commit_hit && commit_kill_i && perf_kill_q != 16'hFFFF) begin
                perf_kill_q <= perf_kill_q + 16'd1;
            end
        end
    end

    assign perf_accepted_o = perf_acc_q;
    assign perf_killed_o   = perf_kill_q;
`else
    assign perf_accepted_o = 16'd0;
    assign perf_killed_o   = 16'd0;
`endif

endmodule

// File: tb/tb_ma_xif_responder.sv
// Self-checking bench for ma_xif_responder: directed scenarios plus a randomized
// issue/commit/dispatch run checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_ma_xif_responder;

    localparam logic [6:0] OPC = 7'b0001011;

    typedef struct {
        logic [2:0]  id;
        logic [1:0]  op;
        logic [4:0]  rd;
        logic        wb;
        logic [31:0] a;
        logic [31:0] b;
        logic        kill;
    } ref_ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready, issue_accept, issue_wb;
    logic [31:0] issue_instr, issue_rs1, issue_rs2;
    logic [2:0]  issue_id;
    logic [1:0]  issue_rs_valid, issue_rr;
    logic        commit_valid, commit_kill;
    logic [2:0]  commit_id;
    logic        result_valid, result_ready, result_we;
    logic [2:0]  result_id;
    logic [31:0] result_data;
    logic [4:0]  result_rd;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_rs1, cmd_rs2;
    logic        done;
    logic [31:0] done_data;
    logic [15:0] perf_acc, perf_kill;

    int total = 0;
    int bad   = 0;
    int exp_acc  = 0;
    int exp_kill = 0;

    always #5 clk = ~clk;

    ma_xif_responder dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .issue_valid_i         (issue_valid),
        .issue_ready_o         (issue_ready),
        .issue_instr_i         (issue_instr),
        .issue_id_i            (issue_id),
        .issue_rs1_i           (issue_rs1),
        .issue_rs2_i           (issue_rs2),
        .issue_rs_valid_i      (issue_rs_valid),
        .issue_accept_o        (issue_accept),
        .issue_writeback_o     (issue_wb),
        .issue_register_read_o (issue_rr),
        .commit_valid_i        (commit_valid),
        .commit_id_i           (commit_id),
        .commit_kill_i         (commit_kill),
        .result_valid_o        (result_valid),
        .result_ready_i        (result_ready),
        .result_id_o           (result_id),
        .result_data_o         (result_data),
        .result_rd_o           (result_rd),
        .result_we_o           (result_we),
        .cmd_valid_o           (cmd_valid),
        .cmd_ready_i           (cmd_ready),
        .cmd_op_o              (cmd_op),
        .cmd_rs1_o             (cmd_rs1),
        .cmd_rs2_o             (cmd_rs2),
        .done_i                (done),
        .done_data_i           (done_data),
        .perf_accepted_o       (perf_acc),
        .perf_killed_o         (perf_kill)
    );

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [16:0] hi);
        return {hi, f3, rd, opc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_instr = 0; issue_id = 0; issue_rs1 = 0; issue_rs2 = 0;
        issue_rs_valid = 0; commit_valid = 0; commit_id = 0; commit_kill = 0;
        cmd_ready = 0; done = 0; done_data = 0; result_ready = 0;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [2:0] id, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] rsv, output logic acc,
                         output logic wb, output logic [1:0] rr, output logic rdy);
        issue_valid = 1; issue_instr = instr; issue_id = id;
        issue_rs1 = a; issue_rs2 = b; issue_rs_valid = rsv;
        #1;
        acc = issue_accept; wb = issue_wb; rr = issue_rr; rdy = issue_ready;
        @(posedge clk);
        #1;
        issue_valid = 0;
    endtask

    task automatic commit(input logic [2:0] id, input logic kill);
        commit_valid = 1; commit_id = id; commit_kill = kill;
        tick();
        commit_valid = 0; commit_kill = 0;
    endtask

    task automatic wait_cmd(input int budget, output logic ok);
        int k = 0;
        ok = 0;
        while (!ok && k < budget) begin
            if (cmd_valid === 1'b1) ok = 1;
            else begin tick(); k++; end
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick(); tick();
        total++; if ({issue_ready, issue_accept, issue_wb, issue_rr, cmd_valid, cmd_op, cmd_rs1, cmd_rs2,
                      result_valid, result_id, result_rd, result_data, result_we} !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", {issue_ready, issue_accept, issue_wb, issue_rr,
                cmd_valid, cmd_op, cmd_rs1, cmd_rs2, result_valid, result_id, result_rd, result_data, result_we});
        end
        total++; if ({perf_acc, perf_kill} !== 32'h0) begin
            bad++; $display("FAIL reset_perf: got %h want 0", {perf_acc, perf_kill});
        end
        rst = 0;
        tick();
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
    endtask

    task automatic test_accept_dispatch();
        logic acc, wb, rdy; logic [1:0] rr;
        issue(mk(OPC, 3'd2, 5'd0, 17'h0), 3'd1, 32'h10, 32'h20, 2'b11, acc, wb, rr, rdy);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL mul_accept: got %b want 1", acc); end
        total++; if (wb !== 1'b0) begin bad++; $display("FAIL mul_wb: got %b want 0", wb); end
        total++; if (rr !== 2'b11) begin bad++; $display("FAIL mul_rr: got %b want 11", rr); end
        commit(3'd1, 1'b0);
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL cmd_early: got %b want 0", cmd_valid); end
        tick();
        total++; if ({cmd_valid, cmd_op, cmd_rs1, cmd_rs2} !== {1'b1, 2'd2, 32'h10, 32'h20}) begin
            bad++; $display("FAIL mul_cmd: got %h want %h", {cmd_valid, cmd_op, cmd_rs1, cmd_rs2},
                            {1'b1, 2'd2, 32'h10, 32'h20});
        end
        cmd_ready = 1; tick(); cmd_ready = 0;
        done = 1; tick(); done = 0; tick();
        total++; if ({cmd_valid, result_valid, issue_ready} !== 3'b001) begin
            bad++; $display("FAIL mul_finish: got %b want 001", {cmd_valid, result_valid, issue_ready});
        end
    endtask

    task automatic test_reject();
        logic acc, wb, rdy; logic [1:0] rr;
        issue(mk(7'b0101011, 3'd2, 5'd1, 17'h0), 3'd4, 32'h1, 32'h2, 2'b11, acc, wb, rr, rdy);
        total++; if (acc !== 1'b0) begin bad++; $display("FAIL rej_opcode: got %b want 0", acc); end
        issue(mk(OPC, 3'd2, 5'd1, 17'h0), 3'd4, 32'h1, 32'h2, 2'b01, acc, wb, rr, rdy);
        total++; if ({acc, rr} !== 3'b000) begin bad++; $display("FAIL rej_rsvalid: got %b want 000", {acc, rr}); end
        issue(mk(OPC, 3'd4, 5'd1, 17'h0), 3'd4, 32'h1, 32'h2, 2'b11, acc, wb, rr, rdy);
        total++; if ({acc, wb} !== 2'b00) begin bad++; $display("FAIL rej_funct3: got %b want 00", {acc, wb}); end
        tick(); tick(); tick();
        total++; if ({issue_ready, cmd_valid} !== 2'b10) begin
            bad++; $display("FAIL rej_empty: got %b want 10", {issue_ready, cmd_valid});
        end
    endtask

    task automatic test_kill();
        logic acc, wb, rdy; logic [1:0] rr;
        logic [31:0] got[$];
        for (int i = 0; i < 3; i++) begin
            issue(mk(OPC, 3'd2, 5'd0, 17'h0), 3'(i), 32'h100 + i, 32'h300 + i, 2'b11, acc, wb, rr, rdy);
            total++; if (acc !== 1'b1) begin bad++; $display("FAIL kill_accept%0d: got %b want 1", i, acc); end
        end
        commit(3'd1, 1'b1);
        commit(3'd0, 1'b0);
        commit(3'd2, 1'b0);
        done = 1; result_ready = 1; cmd_ready = 1;
        for (int c = 0; c < 20; c++) begin
            if (cmd_valid === 1'b1) got.push_back(cmd_rs1);
            tick();
        end
        idle();
        total++; if (got.size() !== 2) begin bad++; $display("FAIL kill_count: got %0d want 2", got.size()); end
        total++; if (((got.size() > 0) ? got[0] : 32'hx) !== 32'h100) begin
            bad++; $display("FAIL kill_first: got %h want 100", (got.size() > 0) ? got[0] : 32'hx);
        end
        total++; if (((got.size() > 1) ? got[1] : 32'hx) !== 32'h102) begin
            bad++; $display("FAIL kill_second: got %h want 102", (got.size() > 1) ? got[1] : 32'hx);
        end
    endtask

    task automatic test_full();
        logic acc, wb, rdy; logic [1:0] rr;
        int k;
        for (int i = 0; i < 4; i++) begin
            issue(mk(OPC, 3'd0, 5'd0, 17'h0), 3'(i), 32'h200 + i, 32'h0, 2'b11, acc, wb, rr, rdy);
            total++; if (acc !== 1'b1) begin bad++; $display("FAIL full_accept%0d: got %b want 1", i, acc); end
        end
        total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", issue_ready); end
        issue(mk(OPC, 3'd0, 5'd0, 17'h0), 3'd4, 32'h0, 32'h0, 2'b11, acc, wb, rr, rdy);
        total++; if ({acc, rdy} !== 2'b00) begin bad++; $display("FAIL full_fifth: got %b want 00", {acc, rdy}); end
        commit(3'd0, 1'b0);
        cmd_ready = 1; done = 1;
        k = 0;
        while (issue_ready !== 1'b1 && k < 10) begin tick(); k++; end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL full_recover: got %b want 1", issue_ready); end
        tick();
        idle();
        commit(3'd1, 1'b1); commit(3'd2, 1'b1); commit(3'd3, 1'b1);
        repeat (6) tick();
        total++; if ({issue_ready, cmd_valid} !== 2'b10) begin
            bad++; $display("FAIL full_drain: got %b want 10", {issue_ready, cmd_valid});
        end
    endtask

    task automatic test_cfg_writeback();
        logic acc, wb, rdy, ok; logic [1:0] rr;
        issue(mk(OPC, 3'd3, 5'd5, 17'h0), 3'd3, 32'h33, 32'h0, 2'b01, acc, wb, rr, rdy);
        total++; if ({acc, wb, rr} !== 4'b1101) begin bad++; $display("FAIL cfg_issue: got %b want 1101", {acc, wb, rr}); end
        commit(3'd3, 1'b0);
        wait_cmd(5, ok);
        total++; if ({ok, cmd_op, cmd_rs1} !== {1'b1, 2'd3, 32'h33}) begin
            bad++; $display("FAIL cfg_cmd: got %h want %h", {ok, cmd_op, cmd_rs1}, {1'b1, 2'd3, 32'h33});
        end
        cmd_ready = 1; tick(); cmd_ready = 0;
        done = 1; done_data = 32'hCAFE; tick(); done = 0; done_data = 32'h1234;
        for (int c = 0; c < 4; c++) begin
            total++; if ({result_valid, result_id, result_rd, result_we, result_data} !== {1'b1, 3'd3, 5'd5, 1'b1, 32'hCAFE}) begin
                bad++; $display("FAIL cfg_result%0d: got %h want %h", c, {result_valid, result_id, result_rd, result_we,
                                result_data}, {1'b1, 3'd3, 5'd5, 1'b1, 32'hCAFE});
            end
            if (c < 3) tick();
        end
        result_ready = 1; tick(); result_ready = 0;
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL cfg_release: got %b want 0", result_valid); end
    endtask

    task automatic test_random();
        ref_ent_t q[$];
        ref_ent_t e;
        int order[$];
        int n, j, t, idx;
        logic [6:0] opc; logic [2:0] f3; logic [4:0] rd; logic [1:0] rsv, need, rr; logic [16:0] hi;
        logic [31:0] a, b, d;
        logic m_acc, acc, wb, rdy, ok, kill;
        rst = 1; tick(); rst = 0; tick();
        exp_acc = 0; exp_kill = 0;
        for (int r = 0; r < 25; r++) begin
            q.delete(); order.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                opc = ($urandom_range(0, 3) == 0) ? 7'($urandom) : OPC;
                f3 = 3'($urandom); rd = 5'($urandom); rsv = 2'($urandom); hi = 17'($urandom);
                a = $urandom; b = $urandom;
                need  = (f3[1:0] == 2'd3) ? 2'b01 : 2'b11;
                m_acc = (opc == OPC) && !f3[2] && ((rsv & need) == need) && (q.size() < 4);
                issue(mk(opc, f3, rd, hi), 3'(i), a, b, rsv, acc, wb, rr, rdy);
                total++; if ({acc, wb, rr} !== {m_acc, m_acc && f3[1:0] == 2'd3, m_acc ? need : 2'b00}) begin
                    bad++; $display("FAIL rnd_issue r%0d i%0d: got %b want %b", r, i, {acc, wb, rr},
                                    {m_acc, m_acc && f3[1:0] == 2'd3, m_acc ? need : 2'b00});
                end
                if (m_acc) begin
                    e.id = 3'(i); e.op = f3[1:0]; e.rd = rd; e.wb = (f3[1:0] == 2'd3);
                    e.a = a; e.b = b; e.kill = 1'b0;
                    q.push_back(e); exp_acc++;
                end
            end
            for (int k = 0; k < q.size(); k++) order.push_back(k);
            for (int k = q.size() - 1; k > 0; k--) begin
                j = $urandom_range(0, k); t = order[k]; order[k] = order[j]; order[j] = t;
            end
            for (int k = 0; k < q.size(); k++) begin
                idx = order[k];
                kill = ($urandom_range(0, 3) == 0);
                q[idx].kill = kill;
                if (kill) exp_kill++;
                commit(q[idx].id, kill);
                if ($urandom_range(0, 3) == 0) commit(3'd7, 1'($urandom));
            end
            for (int k = 0; k < q.size(); k++) begin
                if (!q[k].kill) begin
                    wait_cmd(20, ok);
                    total++; if ({ok, cmd_op, cmd_rs1, cmd_rs2} !== {1'b1, q[k].op, q[k].a, q[k].b}) begin
                        bad++; $display("FAIL rnd_cmd r%0d k%0d: got %h want %h", r, k, {ok, cmd_op, cmd_rs1, cmd_rs2},
                                        {1'b1, q[k].op, q[k].a, q[k].b});
                    end
                    repeat ($urandom_range(0, 2)) tick();
                    cmd_ready = 1; tick(); cmd_ready = 0;
                    repeat ($urandom_range(0, 2)) tick();
                    d = $urandom;
                    done = 1; done_data = d; tick(); done = 0;
                    if (q[k].wb) begin
                        total++; if ({result_valid, result_we, result_id, result_rd, result_data} !==
                                     {2'b11, q[k].id, q[k].rd, d}) begin
                            bad++; $display("FAIL rnd_result r%0d k%0d: got %h want %h", r, k, {result_valid, result_we,
                                result_id, result_rd, result_data}, {2'b11, q[k].id, q[k].rd, d});
                        end
                        repeat ($urandom_range(0, 2)) tick();
                        result_ready = 1; tick(); result_ready = 0;
                    end else begin
                        total++; if (result_valid !== 1'b0) begin
                            bad++; $display("FAIL rnd_noresult r%0d k%0d: got %b want 0", r, k, result_valid);
                        end
                    end
                end
            end
            repeat (6) tick();
            total++; if ({issue_ready, cmd_valid, result_valid} !== 3'b100) begin
                bad++; $display("FAIL rnd_drain r%0d: got %b want 100", r, {issue_ready, cmd_valid, result_valid});
            end
        end
`ifdef MA_XIF_PERF_CNT_EN
        total++; if ({perf_acc, perf_kill} !== {16'(exp_acc), 16'(exp_kill)}) begin
            bad++; $display("FAIL rnd_perf: got %0d/%0d want %0d/%0d", perf_acc, perf_kill, exp_acc, exp_kill);
        end
`else
        total++; if ({perf_acc, perf_kill} !== 32'h0) begin
            bad++; $display("FAIL rnd_perf_off: got %h want 0", {perf_acc, perf_kill});
        end
`endif
    endtask

    task automatic test_reset_midflight();
        logic acc, wb, rdy, ok; logic [1:0] rr;
        issue(mk(OPC, 3'd2, 5'd0, 17'h0), 3'd2, 32'h77, 32'h88, 2'b11, acc, wb, rr, rdy);
        commit(3'd2, 1'b0);
        wait_cmd(5, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL mid_cmd: got %b want 1", ok); end
        cmd_ready = 1; tick(); cmd_ready = 0;
        rst = 1; tick();
        total++; if ({issue_ready, issue_accept, cmd_valid, cmd_op, cmd_rs1, cmd_rs2, result_valid, result_id,
                      result_rd, result_data, result_we, perf_acc, perf_kill} !== '0) begin
            bad++; $display("FAIL mid_reset_outputs: got %h want 0", {issue_ready, issue_accept, cmd_valid, cmd_op,
                cmd_rs1, cmd_rs2, result_valid, result_id, result_rd, result_data, result_we, perf_acc, perf_kill});
        end
        rst = 0;
        done = 1; done_data = 32'hBEEF; tick(); done = 0; tick();
        total++; if ({result_valid, cmd_valid, issue_ready} !== 3'b001) begin
            bad++; $display("FAIL mid_late_done: got %b want 001", {result_valid, cmd_valid, issue_ready});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_accept_dispatch();
        test_reject();
        test_kill();
        test_full();
        test_cfg_writeback();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ma_xif_responder.md
# ma_xif_responder

Coprocessor-side responder for the CV-X-IF port of the CVA6 core (`CvxifEn=1`, 32-bit XLEN). It sits between the core's X-interface and the matrix engine. The block:
- decodes custom-0 matrix instructions and accepts or rejects them;
- buffers accepted instructions until the core commits or kills them;
- dispatches committed instructions to the engine in order, one at a time;
- returns register writeback results to the core.

## Interface
Parameters:
- `Depth`, 4: instruction buffer entries (power of two, ≥2).
- `IdWidth`, 3: CV-X-IF instruction id width.
- `XLEN`, 32: register width.

Ports:
- `clk_i` in 1: the only clock.
- `rst_i` in 1: synchronous, active-high reset.
- `issue_valid_i` in 1: issue request.
- `issue_ready_o` out 1: responder can take an issue.
- `issue_instr_i` in 32: instruction word.
- `issue_id_i` in IdWidth: instruction id.
- `issue_rs1_i`, `issue_rs2_i` in XLEN: source operands.
- `issue_rs_valid_i` in 2: operand valid flags; bit 0 is rs1, bit 1 is rs2.
- `issue_accept_o` out 1: instruction accepted.
- `issue_writeback_o` out 1: accepted instruction will write rd.
- `issue_register_read_o` out 2: operands consumed.
- `commit_valid_i` in 1: commit event.
- `commit_id_i` in IdWidth: id being committed.
- `commit_kill_i` in 1: 1 kills the instruction, 0 commits it.
- `result_valid_o` out 1: result available.
- `result_ready_i` in 1: core takes the result.
- `result_id_o` out IdWidth: id of the result.
- `result_data_o` out XLEN: result value.
- `result_rd_o` out 5: destination register.
- `result_we_o` out 1: register write enable.
- `cmd_valid_o` out 1: engine command valid.
- `cmd_ready_i` in 1: engine takes the command.
- `cmd_op_o` out 2: engine opcode.
- `cmd_rs1_o`, `cmd_rs2_o` out XLEN: command operands.
- `done_i` in 1: engine completion pulse.
- `done_data_i` in XLEN: engine return value, valid with `done_i`.
- `perf_accepted_o` out 16: count of accepted instructions.
- `perf_killed_o` out 16: count of killed instructions.

## Operation
**Decode (combinational).** An instruction matches when opcode[6:0] = 7'b0001011. The op is taken from funct3[1:0]:
- 0 = LD: needs rs1, rs2; no writeback.
- 1 = ST: needs rs1, rs2; no writeback.
- 2 = MUL: needs rs1, rs2; no writeback.
- 3 = CFG: needs rs1 only; writes rd.
- funct3[2] = 1: reject.

**Accept rule.** `issue_accept_o` = `issue_valid_i` & match & all needed `rs_valid` bits set & buffer not full.
- `issue_writeback_o` and `issue_register_read_o` are 0 unless accepted.
- `issue_ready_o` = buffer not full.
- An issue while the buffer is full gets ready = 0 and accept = 0.

**Buffer.** Circular, with head/tail pointers and a count of width clog2(Depth)+1. Each entry holds: id, op, rd, writeback flag, rs1, rs2, and a state of PEND, COMMIT or KILL.
- An accepted issue allocates the tail entry as PEND.
- A commit sets the state of the PEND entry whose id equals `commit_id_i` to COMMIT (kill = 0) or KILL (kill = 1).
- A commit with an unknown id is ignored.
- A commit arriving in the same cycle as the matching issue is a protocol violation and is ignored.

**Dispatch FSM.**
- IDLE:
  - head is KILL: pop it, stay in IDLE.
  - head is COMMIT: register the command, go to DISPATCH.
- DISPATCH: `cmd_valid_o` = 1; on `cmd_ready_i`, pop head and go to WAIT.
- WAIT: on `done_i`:
  - writeback set: latch `done_data_i`, go to RESULT.
  - otherwise: go to IDLE.
- RESULT: `result_valid_o` = 1 with `result_we_o` = 1; on `result_ready_i`, go to IDLE.
- An allocation and a pop in the same cycle keep count unchanged. Pointers wrap modulo Depth.

## Timing
- **Reset.** All outputs are 0 on the first edge with `rst_i` = 1. Reset clears every entry, the pointers, the count, the counters, and returns the FSM to IDLE, including when a command or result is in flight.
- **Issue response.** Same cycle as `issue_valid_i`, combinational.
- **Commit to command.** A COMMIT head while the FSM is IDLE raises `cmd_valid_o` 2 cycles after the commit edge: commit is registered, IDLE loads the command, then DISPATCH.
- **Hold rules.**
  - `cmd_*` are held stable while valid and not ready.
  - `result_*` are held stable until `result_ready_i`.
- **Throughput.** At most one command is outstanding. `done_i` received outside WAIT is ignored.

## Configuration
- Macro: `MA_XIF_PERF_CNT_EN`.
- Defined:
  - `perf_accepted_o` increments on each accepted issue.
  - `perf_killed_o` increments on each kill that matches an entry.
  - Both saturate at 16'hFFFF.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- Package `ma_xif_pkg` holds:
  - constant `MA_OPCODE` = 7'b0001011;
  - `ma_op_e` {LD, ST, MUL, CFG};
  - `entry_state_e` {PEND, COMMIT, KILL};
  - `ma_xif_entry_t` struct;
  - `disp_state_e` {IDLE, DISPATCH, WAIT, RESULT}.
- Sub-module `ma_xif_decoder`: combinational match, op, writeback and needed-operand decode.

## Test plan
- **Accept and dispatch.** Issue MUL (funct3 = 2), id = 1, rs1 = 0x10, rs2 = 0x20, `rs_valid` = 2'b11 -> accept = 1, writeback = 0. Then commit id 1 -> `cmd_valid_o` 2 cycles later with op = 2, rs1 = 0x10, rs2 = 0x20.
- **Reject.** Issue with opcode 7'b0101011 -> accept = 0. Issue MUL with `rs_valid` = 2'b01 -> accept = 0. Issue with funct3 = 4 -> accept = 0.
- **Kill.** Accept ids 0, 1, 2; kill id 1; commit ids 0 and 2 -> exactly two commands, for ids 0 and 2, in that order.
- **Full.** Accept 4 without committing -> `issue_ready_o` = 0 and a 5th issue gets accept = 0. Commit one and let it dispatch -> ready returns to 1.
- **CFG writeback.** Issue CFG, rd = 5, id = 3; commit; engine `done_i` with 0xCAFE -> `result_valid_o` with id = 3, rd = 5, we = 1, data = 0xCAFE. Holding `result_ready_i` = 0 for 3 cycles keeps all of these stable.
- **Reset mid-flight.** Assert `rst_i` during WAIT -> next cycle all outputs are 0 and a late `done_i` produces no result. With `MA_XIF_PERF_CNT_EN` defined, the counters read 0.
